temp_sample_ctrl: RTL and testbench
===================================

Name: temp_sample_ctrl

Overview:
Sequencer that drives the load/store strobes of the temperature/measurement-system register bank (4-bit temp, 2-bit unit system). It samples the sensor inputs on a fixed period and commits each sample in a two-phase load-then-store handshake. It also maintains running min/max and a sample counter, so downstream display logic reads stable registered values only.

Parameters:
PERIOD, 8, cycles between successive LOAD strobes; legal range 3..255.
TW, 4, temperature width.
CW, 8, sample counter width.

Ports:
clk  in  1  system clock, all logic on rising edge
clr  in  1  synchronous active-high reset
start  in  1  level; begins periodic sampling from IDLE
halt  in  1  level; stops sampling (see rules)
temp_in  in  TW  raw temperature
sys_in  in  2  measurement-system code
ld  out  1  one-cycle load strobe to register bank
st  out  1  one-cycle store strobe to register bank
temp_q  out  TW  last committed temperature
sys_q  out  2  last committed system code
min_q  out  TW  minimum committed temp since clear/unit change
max_q  out  TW  maximum committed temp since clear/unit change
sample_cnt  out  CW  committed samples, saturating
sample_vld  out  1  one-cycle pulse, same cycle as commit
busy  out  1  high in any state except IDLE

Behaviour:
- One clock domain (clk); reset clr is synchronous and active-high. clr=1 at a rising edge: state IDLE; all outputs 0; wait counter 0; first-sample flag set. clr overrides every other input, including mid-handshake.
- States: IDLE, LOAD, STORE, WAIT. Encoding belongs to the package.
- IDLE: ld=st=0. start=1 and halt=0 -> LOAD. start and halt both high -> stay IDLE (halt wins).
- LOAD (1 cycle): ld=1. temp_in/sys_in captured into staging registers on this edge. Always -> STORE.
- STORE (1 cycle): st=1. Staging is copied to temp_q/sys_q on this edge. sample_vld=1 in this cycle. sample_cnt increments; it holds at 2^CW-1. Min/max update on the same edge.
- STORE exit: halt=1 -> IDLE; else -> WAIT with counter = PERIOD-3.
- WAIT: counter decrements each cycle. counter==0 and halt=0 -> LOAD. halt=1 -> IDLE on the next edge, no further strobes.
- Timing: WAIT lasts PERIOD-2 cycles, so LOAD-to-LOAD spacing is exactly PERIOD cycles. Load-to-commit latency is 1 cycle.
- Handshake atomicity: halt during LOAD does not abort. STORE still occurs; ld is never issued without the following st.
- Min/max: on a commit with first-sample flag set, or with staged sys != current sys_q, min_q=max_q=staged temp and the flag clears. Otherwise min_q=min(min_q,temp) and max_q=max(max_q,temp), unsigned compare.
- Unit change alone does not reset sample_cnt.
- temp_q, sys_q, min_q, max_q and sample_cnt hold their values in IDLE after halt. Only clr zeroes them.
- ld and st are never high in the same cycle.

Decomposition:
- Package temp_ctrl_pkg holds:
  - state_t enum (IDLE, LOAD, STORE, WAIT)
  - TW/CW default constants
  - sys-code constants (00 C, 01 F, 10 K, 11 reserved; informational only, the block does not decode them)
- One sub-module: minmax_tracker. Inputs: clk, clr, commit, reinit, value. Outputs: min_q, max_q. It owns the first-sample flag.

Test Plan:
- Reset: clr held 3 cycles mid-WAIT -> next cycle state IDLE; ld=st=busy=0; temp_q=min_q=max_q=sample_cnt=0.
- Periodic run: PERIOD=8, start=1, temp_in=5, sys_in=00 -> ld at cycle 1, st at cycle 2, next ld at cycle 9; after 3 commits sample_cnt=3, temp_q=5, min_q=max_q=5.
- Min/max: commit sequence 7,3,12,9 in the same unit -> min_q=3, max_q=12, temp_q=9.
- Unit change: after the previous sequence, commit temp=6 with sys_in=01 -> min_q=max_q=6, sys_q=01, sample_cnt continues (+1).
- Halt timing: halt asserted in LOAD -> st still pulses next cycle, then IDLE, busy=0; halt in WAIT -> IDLE next edge, no ld. start and halt together in IDLE -> no strobes.
- Saturation: CW=3, run 10 commits -> sample_cnt stops at 7; sample_vld still pulses on every commit.

Source files
------------

// File: rtl/temp_ctrl_pkg.sv
// Shared types and constants for the temperature sample sequencer.
// State encoding lives here so the top and any monitors agree on it.
package temp_ctrl_pkg;

    localparam int TW_DEF     = 4;
    localparam int CW_DEF     = 8;
    localparam int PERIOD_DEF = 8;

    // Wide enough to hold PERIOD-3 for the largest legal PERIOD (255).
    localparam int WCNT_W = 8;

    // Measurement-system codes; carried through unchanged, never decoded here.
    localparam logic [1:0] SYS_C    = 2'b00;
    localparam logic [1:0] SYS_F    = 2'b01;
    localparam logic [1:0] SYS_K    = 2'b10;
    localparam logic [1:0] SYS_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        STORE = 2'b10,
        WAIT  = 2'b11
    } state_t;

endpackage

// File: rtl/minmax_tracker.sv
// Running unsigned min/max of committed temperatures.
// Owns the first-sample flag so the first commit after clr seeds both bounds.
module minmax_tracker
    import temp_ctrl_pkg::*;
#(
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          commit,
    input  logic          reinit,
    input  logic [TW-1:0] value,
    output logic [TW-1:0] min_q,
    output logic [TW-1:0] max_q
);

    logic          r_first;
    logic [TW-1:0] r_min;
    logic [TW-1:0] r_max;
    logic          w_seed;

    assign w_seed = r_first || reinit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_first <= 1'b1;
            r_min   <= '0;
            r_max   <= '0;
        end else if (commit) begin
            r_first <= 1'b0;
            if (w_seed) begin
                r_min <= value;
                r_max <= value;
            end else begin
                if (value < r_min) r_min <= value;
                if (value > r_max) r_max <= value;
            end
        end
    end

    assign min_q = r_min;
    assign max_q = r_max;

endmodule

// File: rtl/temp_sample_ctrl.sv
// Periodic load/store sequencer for the temperature register bank, with
// committed-value registers, running min/max and a saturating sample count.
module temp_sample_ctrl
    import temp_ctrl_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int TW     = TW_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          halt,
    input  logic [TW-1:0] temp_in,
    input  logic [1:0]    sys_in,
    output logic          ld,
    output logic          st,
    output logic [TW-1:0] temp_q,
    output logic [1:0]    sys_q,
    output logic [TW-1:0] min_q,
    output logic [TW-1:0] max_q,
    output logic [CW-1:0] sample_cnt,
    output logic          sample_vld,
    output logic          busy
);

    localparam logic [CW-1:0]     CNT_MAX   = '1;
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(PERIOD - 3);

    state_t            r_state;
    state_t            w_next_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [TW-1:0]     r_stage_temp;
    logic [1:0]        r_stage_sys;
    logic [TW-1:0]     r_temp_q;
    logic [1:0]        r_sys_q;
    logic [CW-1:0]     r_sample_cnt;
    logic              w_commit;
    logic              w_reinit;

    always_ff @(posedge clk) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: next state defaults to the current state before the case so no
    // path through this block leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:  if (start && !halt) w_next_state = LOAD;
            LOAD:  w_next_state = STORE;
            STORE: w_next_state = halt ? IDLE : WAIT;
            WAIT: begin
                if (halt)                  w_next_state = IDLE;
                else if (r_wait_cnt == '0) w_next_state = LOAD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Reloaded on every commit; only consulted while in WAIT.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_wait_cnt <= '0;
        end else if (r_state == STORE) begin
            r_wait_cnt <= WAIT_INIT;
        end else if (r_state == WAIT && r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    assign w_commit = (r_state == STORE);
    assign w_reinit = (r_stage_sys != r_sys_q);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_stage_temp <= '0;
            r_stage_sys  <= '0;
            r_temp_q     <= '0;
            r_sys_q      <= '0;
            r_sample_cnt <= '0;
        end else begin
            if (r_state == LOAD) begin
                r_stage_temp <= temp_in;
                r_stage_sys  <= sys_in;
            end
            if (w_commit) begin
                r_temp_q <= r_stage_temp;
                r_sys_q  <= r_stage_sys;
                if (r_sample_cnt != CNT_MAX) r_sample_cnt <= r_sample_cnt + 1'b1;
            end
        end
    end

    minmax_tracker #(
        .TW(TW)
    ) u_minmax (
        .clk    (clk),
        .clr    (clr),
        .commit (w_commit),
        .reinit (w_reinit),
        .value  (r_stage_temp),
        .min_q  (min_q),
        .max_q  (max_q)
    );

    // Strobes decode straight from state, so ld and st are mutually exclusive.
    assign ld         = (r_state == LOAD);
    assign st         = (r_state == STORE);
    assign sample_vld = w_commit;
    assign busy       = (r_state != IDLE);
    assign temp_q     = r_temp_q;
    assign sys_q      = r_sys_q;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Directed bench for temp_sample_ctrl: main instance (PERIOD=8, CW=8) and a
// second instance (PERIOD=3, CW=3) for counter saturation.
module tb_temp_sample_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic       clr, start, halt;
    logic [3:0] temp_in;
    logic [1:0] sys_in;
    logic       ld, st, sample_vld, busy;
    logic [3:0] temp_q, min_q, max_q;
    logic [1:0] sys_q;
    logic [7:0] sample_cnt;

    // Saturation instance
    logic       s_clr, s_start, s_halt;
    logic [3:0] s_temp_in;
    logic [1:0] s_sys_in;
    logic       s_ld, s_st, s_sample_vld, s_busy;
    logic [3:0] s_temp_q, s_min_q, s_max_q;
    logic [1:0] s_sys_q;
    logic [2:0] s_sample_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int n_overlap = 0;

    temp_sample_ctrl #(.PERIOD(8), .TW(4), .CW(8)) dut (
        .clk(clk), .clr(clr), .start(start), .halt(halt),
        .temp_in(temp_in), .sys_in(sys_in),
        .ld(ld), .st(st), .temp_q(temp_q), .sys_q(sys_q),
        .min_q(min_q), .max_q(max_q), .sample_cnt(sample_cnt),
        .sample_vld(sample_vld), .busy(busy)
    );

    temp_sample_ctrl #(.PERIOD(3), .TW(4), .CW(3)) dut_sat (
        .clk(clk), .clr(s_clr), .start(s_start), .halt(s_halt),
        .temp_in(s_temp_in), .sys_in(s_sys_in),
        .ld(s_ld), .st(s_st), .temp_q(s_temp_q), .sys_q(s_sys_q),
        .min_q(s_min_q), .max_q(s_max_q), .sample_cnt(s_sample_cnt),
        .sample_vld(s_sample_vld), .busy(s_busy)
    );

    always @(negedge clk) begin
        if ((ld && st) || (s_ld && s_st)) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present the next sample, step until its STORE cycle, then one more
    // cycle so the committed values are visible.
    task automatic commit_next(input logic [3:0] t, input logic [1:0] s, output bit ok);
        temp_in = t;
        sys_in  = s;
        ok      = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (st) ok = 1'b1;
        end
        tick();
    endtask

    task automatic wait_ld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (ld) ok = 1'b1;
        end
    endtask

    task automatic watch(input int n, output int lds, output int sts);
        lds = 0;
        sts = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ld) lds++;
            if (st) sts++;
        end
    endtask

    initial begin
        bit ok;
        int lds, sts, vlds;

        clr = 1'b1; start = 1'b0; halt = 1'b0; temp_in = '0; sys_in = '0;
        s_clr = 1'b1; s_start = 1'b0; s_halt = 1'b0; s_temp_in = 4'd1; s_sys_in = '0;
        tick();
        tick();
        clr = 1'b0;
        s_clr = 1'b0;

        check("rst_ld",   ld, 0);
        check("rst_st",   st, 0);
        check("rst_busy", busy, 0);
        check("rst_temp", temp_q, 0);
        check("rst_cnt",  sample_cnt, 0);
        check("rst_min",  min_q, 0);
        check("rst_max",  max_q, 0);

        // Periodic run: start in cycle 0
        start = 1'b1; temp_in = 4'd5; sys_in = 2'b00;
        tick();
        check("c1_ld",   ld, 1);
        check("c1_st",   st, 0);
        check("c1_busy", busy, 1);
        tick();
        check("c2_ld",  ld, 0);
        check("c2_st",  st, 1);
        check("c2_vld", sample_vld, 1);
        check("c2_cnt_before_commit", sample_cnt, 0);
        tick();
        check("c3_st",   st, 0);
        check("c3_vld",  sample_vld, 0);
        check("c3_temp", temp_q, 5);
        check("c3_cnt",  sample_cnt, 1);
        for (int i = 0; i < 5; i++) tick();
        check("c8_ld", ld, 0);
        tick();
        check("c9_ld", ld, 1);
        commit_next(4'd5, 2'b00, ok); check("seen2", ok, 1);
        commit_next(4'd5, 2'b00, ok); check("seen3", ok, 1);
        check("p_cnt",  sample_cnt, 3);
        check("p_temp", temp_q, 5);
        check("p_min",  min_q, 5);
        check("p_max",  max_q, 5);

        // Min/max sequence in the same unit
        commit_next(4'd7,  2'b00, ok); check("seen_7", ok, 1);
        check("mm_max_7", max_q, 7);
        commit_next(4'd3,  2'b00, ok); check("seen_3", ok, 1);
        commit_next(4'd12, 2'b00, ok); check("seen_12", ok, 1);
        commit_next(4'd9,  2'b00, ok); check("seen_9", ok, 1);
        check("mm_min",  min_q, 3);
        check("mm_max",  max_q, 12);
        check("mm_temp", temp_q, 9);
        check("mm_cnt",  sample_cnt, 7);

        // Unit change reseeds min/max, count keeps going
        commit_next(4'd6, 2'b01, ok); check("seen_unit", ok, 1);
        check("u_min", min_q, 6);
        check("u_max", max_q, 6);
        check("u_sys", sys_q, 1);
        check("u_cnt", sample_cnt, 8);

        // Halt during LOAD: STORE still happens, then IDLE
        temp_in = 4'd10; sys_in = 2'b01;
        wait_ld(ok); check("hl_ld_seen", ok, 1);
        halt = 1'b1;
        tick();
        check("hl_st", st, 1);
        tick();
        check("hl_busy", busy, 0);
        check("hl_ld",   ld, 0);
        check("hl_temp", temp_q, 10);
        check("hl_min",  min_q, 6);
        check("hl_max",  max_q, 10);
        check("hl_cnt",  sample_cnt, 9);

        // start and halt together in IDLE: nothing happens, values hold
        watch(10, lds, sts);
        check("sh_lds", lds, 0);
        check("sh_sts", sts, 0);
        check("sh_cnt", sample_cnt, 9);
        check("sh_temp", temp_q, 10);

        // Halt during WAIT
        halt = 1'b0;
        commit_next(4'd2, 2'b01, ok); check("seen_2", ok, 1);
        check("hw_min", min_q, 2);
        check("hw_busy_wait", busy, 1);
        halt = 1'b1;
        tick();
        check("hw_busy", busy, 0);
        watch(10, lds, sts);
        check("hw_lds", lds, 0);
        check("hw_temp", temp_q, 2);
        check("hw_cnt", sample_cnt, 10);

        // clr held three cycles mid-WAIT
        halt = 1'b0;
        commit_next(4'd8, 2'b01, ok); check("seen_8", ok, 1);
        check("r_cnt_before", sample_cnt, 11);
        clr = 1'b1;
        tick(); tick(); tick();
        check("r_busy", busy, 0);
        check("r_ld",   ld, 0);
        check("r_st",   st, 0);
        check("r_vld",  sample_vld, 0);
        check("r_temp", temp_q, 0);
        check("r_sys",  sys_q, 0);
        check("r_min",  min_q, 0);
        check("r_max",  max_q, 0);
        check("r_cnt",  sample_cnt, 0);
        clr = 1'b0;

        // First commit after clr seeds min/max even with unchanged unit
        commit_next(4'd4, 2'b00, ok); check("seen_4", ok, 1);
        check("f_min", min_q, 4);
        check("f_max", max_q, 4);
        check("f_cnt", sample_cnt, 1);

        // Saturation: PERIOD=3, CW=3, ten commits in 30 cycles
        s_start = 1'b1;
        vlds = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_sample_vld) vlds++;
        end
        s_halt = 1'b1;
        tick();
        tick();
        check("sat_vld_pulses", vlds, 10);
        check("sat_cnt", s_sample_cnt, 7);
        check("sat_busy", s_busy, 0);

        check("ld_st_overlap", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
